// File: rtl/usb_da_sample_buffer.sv
// usb_da_sample_buffer
//
// Sits behind the FX3 slave-FIFO read controller on the USB3-to-DAC path.
// Words read from the FX3 DQ bus are captured after the FX3 read latency,
// stored in a first-word-fall-through FIFO, split into two 16-bit samples
// (low half first) and paced out to the DAC at clk / (div + 1).
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   DQ              FX3 data bus (32 bit)
//   SLCS/SLOE/SLRD  active-low strobes from the read controller
//   DATA_DIR        0 = USB-to-device; capture is only enabled when 0
//   enable          playback enable; low flushes the buffer
//   div             sample period minus 1, in clk cycles
//   dac_data        sample to the DAC
//   dac_strobe      one-cycle pulse when dac_data takes a new value
//   buf_level       number of stored words
//   buf_afull       almost-full flag for the read controller
//   running         high while samples are being played
//   underrun_cnt    saturating count of underruns
//   overflow_cnt    saturating count of words dropped on a full buffer

module usb_da_sample_buffer #(
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned PRIME_LEVEL  = 512,
  parameter int unsigned AFULL_MARGIN = 16,
  parameter logic [15:0] MIDSCALE     = 16'h8000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         DQ,
  input  logic                SLCS,
  input  logic                SLOE,
  input  logic                SLRD,
  input  logic                DATA_DIR,
  input  logic                enable,
  input  logic [15:0]         div,
  output logic [15:0]         dac_data,
  output logic                dac_strobe,
  output logic [DEPTH_LOG2:0] buf_level,
  output logic                buf_afull,
  output logic                running,
  output logic [15:0]         underrun_cnt,
  output logic [15:0]         overflow_cnt
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0]   lvl_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  localparam lvl_t DepthLvl = lvl_t'(Depth);
  localparam lvl_t AfullLvl = lvl_t'(Depth - AFULL_MARGIN);
  localparam lvl_t PrimeLvl = lvl_t'(PRIME_LEVEL);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  // ---------------------------------------------------------------------------
  // Capture pipeline: a read hit becomes a FIFO write RD_LAT clocks later,
  // which is when the FX3 actually drives the requested word onto DQ.
  // ---------------------------------------------------------------------------
  logic              rd_hit;
  logic [RD_LAT-1:0] hit_q;
  logic [RD_LAT:0]   hit_d;
  logic              wr_en;

  assign rd_hit = ~SLCS & ~SLOE & ~SLRD & ~DATA_DIR;
  assign hit_d  = {hit_q, rd_hit};
  assign wr_en  = hit_d[RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d[RD_LAT-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and occupancy
  // ---------------------------------------------------------------------------
  logic [31:0] mem [Depth];
  ptr_t        wr_ptr_q, rd_ptr_q;
  lvl_t        level_q;
  logic        afull_q;
  logic [15:0] overflow_q;
  logic [31:0] head;
  logic        full, empty, push, drop, pop, tick;

  // Playback state (declared here because pop depends on it)
  state_e      state_q;
  logic [15:0] cnt_q, div_q;
  logic        phase_q;
  logic [15:0] upper_q;
  logic [15:0] dac_q;
  logic        strobe_q;
  logic        running_q;
  logic [15:0] underrun_q;

  // Full/empty use the level at the start of the cycle, so a pop never makes
  // room for a same-cycle write and a same-cycle write never hides an underrun.
  assign full  = (level_q == DepthLvl);
  assign empty = (level_q == '0);
  assign push  = enable & wr_en & ~full;
  assign drop  = enable & wr_en & full;
  assign tick  = enable & (state_q == StRun) & (cnt_q == div_q);
  assign pop   = tick & ~phase_q & ~empty;
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= DQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (!enable) begin
      // Disabled: buffer is flushed and captured words are discarded.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + lvl_t'(1);
        2'b01:   level_q <= level_q - lvl_t'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      afull_q    <= 1'b0;
      overflow_q <= '0;
    end else begin
      afull_q <= (level_q >= AfullLvl);
      if (drop && (overflow_q != 16'hFFFF)) begin
        overflow_q <= overflow_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Playback FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      upper_q    <= '0;
      dac_q      <= MIDSCALE;
      strobe_q   <= 1'b0;
      running_q  <= 1'b0;
      underrun_q <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (!enable) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        phase_q   <= 1'b0;
        dac_q     <= MIDSCALE;
        running_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StPrime;
          end
          StPrime: begin
            if (level_q >= PrimeLvl) begin
              state_q   <= StRun;
              running_q <= 1'b1;
              cnt_q     <= '0;
              div_q     <= div;
            end
          end
          StRun: begin
            if (tick) begin
              // div is only sampled at a wrap so a period in flight completes.
              cnt_q <= '0;
              div_q <= div;
              if (phase_q) begin
                dac_q    <= upper_q;
                strobe_q <= 1'b1;
                phase_q  <= 1'b0;
              end else if (!empty) begin
                dac_q    <= head[15:0];
                upper_q  <= head[31:16];
                strobe_q <= 1'b1;
                phase_q  <= 1'b1;
              end else begin
                // Underrun: park at midscale and wait for a fresh prime.
                dac_q     <= MIDSCALE;
                state_q   <= StPrime;
                running_q <= 1'b0;
                if (underrun_q != 16'hFFFF) begin
                  underrun_q <= underrun_q + 16'd1;
                end
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          default: begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dac_data     = dac_q;
  assign dac_strobe   = strobe_q;
  assign buf_level    = level_q;
  assign buf_afull    = afull_q;
  assign running      = running_q;
  assign underrun_cnt = underrun_q;
  assign overflow_cnt = overflow_q;

endmodule

// File: doc/usb_da_sample_buffer.md
Name: usb_da_sample_buffer

Overview:
- Downstream stage of the FX3 slave-FIFO read controller in the USB3-to-DA path.
- Captures 32-bit words from the FX3 DQ bus, applying the FX3 read latency to the controller's SLCS/SLOE/SLRD strobes.
- Buffers the words in an internal FIFO, splits each word into two 16-bit samples, and paces them to the DAC at a programmable rate.
- Provides fill-level, almost-full and error counters so the read controller and the host can throttle and diagnose.

Parameters:
- DEPTH_LOG2, 10, FIFO depth = 2^DEPTH_LOG2 32-bit words.
- RD_LAT, 2, clocks from an SLRD-low sample edge to valid DQ at this block's input.
- PRIME_LEVEL, 512, minimum stored words required before playback starts or restarts.
- AFULL_MARGIN, 16, buf_afull asserts when level >= 2^DEPTH_LOG2 - AFULL_MARGIN.
- MIDSCALE, 16'h8000, DAC code driven when idle or on underrun.

Ports:
- clk  in  1  system clock; same clock as the FX3 interface and the read controller.
- rst  in  1  asynchronous, active-high reset.
- DQ  in  32  FX3 data bus.
- SLCS  in  1  chip select from the read controller, active low.
- SLOE  in  1  output enable from the read controller, active low.
- SLRD  in  1  read strobe from the read controller, active low.
- DATA_DIR  in  1  0 = USB-to-device direction; capture is enabled only when 0.
- enable  in  1  playback enable.
- div  in  16  sample period minus 1, in clk cycles.
- dac_data  out  16  sample to the DAC.
- dac_strobe  out  1  one-cycle pulse when dac_data takes a new value.
- buf_level  out  DEPTH_LOG2+1  number of stored words.
- buf_afull  out  1  almost-full flag, fed back to the read controller.
- running  out  1  high in the RUN state.
- underrun_cnt  out  16  saturating count of underruns.
- overflow_cnt  out  16  saturating count of dropped words.

Behaviour:
- Reset values:
  - dac_data = MIDSCALE; dac_strobe = 0; buf_level = 0; buf_afull = 0; running = 0; both counters = 0.
  - FIFO empty, state IDLE, phase = 0, capture pipeline cleared.
  - Reset mid-operation discards all buffered data.
- Capture:
  - rd_hit = ~SLCS & ~SLOE & ~SLRD & ~DATA_DIR, sampled each clk.
  - rd_hit is delayed RD_LAT stages. When the delayed bit is 1, DQ is written to the FIFO in that cycle.
- Overflow:
  - A write is dropped if the level at the start of the cycle equals 2^DEPTH_LOG2, even if a pop happens in the same cycle.
  - Each dropped write increments overflow_cnt, saturating at 16'hFFFF.
- While enable = 0, captured words are discarded and not counted.
- FIFO:
  - First-word-fall-through; the head word is readable without a pop.
  - buf_level tracks push/pop exactly and is registered: it reflects a push or pop the cycle after it occurs.
  - Simultaneous push and pop leaves the level unchanged.
  - buf_afull is registered from buf_level.
- States:
  - IDLE: enable = 0. FIFO flushed, phase = 0, dac_data = MIDSCALE. Go to PRIME when enable = 1.
  - PRIME: dac_data holds its last value. Go to RUN once buf_level >= PRIME_LEVEL; the divider counter resets to 0 on entry to RUN.
  - RUN: running = 1. The divider counts 0..div; tick when count == div. div = 0 gives a tick every cycle. A new div value takes effect at the next wrap.
  - enable = 0 in any state returns to IDLE on the next cycle. Counters are retained; FIFO and phase are cleared.
- Tick in RUN:
  - phase 0, FIFO not empty: dac_data <= head[15:0]; store head[31:16]; pop; phase <= 1; dac_strobe = 1 in the cycle dac_data takes the new value.
  - phase 1: dac_data <= stored upper half; phase <= 0; strobe as above. No FIFO access.
  - phase 0, FIFO empty: this is an underrun. dac_data <= MIDSCALE, no strobe, underrun_cnt += 1 (saturating), state <= PRIME.
  - A word written in the same cycle as an underrun tick is not visible and does not prevent the underrun.
- Ordering: samples leave in strict word order, low half before high half. No duplication or loss except on overflow or when enable = 0.

Test Plan:
- Reset, then enable = 1 with no writes -> state stays PRIME, dac_data = 16'h8000, running = 0, no strobes.
- 512 reads of words {k+1, k} for k = 0,2,4,…; div = 3 -> running rises after the 512th write lands. Strobes come every 4 clks. dac_data sequence is 0,1,2,3,…,1023, then underrun: dac_data = 16'h8000, underrun_cnt = 1, return to PRIME.
- Latency check: single SLRD-low cycle with SLCS = SLOE = 0 and DQ = 32'hA5A5_1234 presented at cycle t+2 -> exactly one word stored, buf_level = 1 at t+3. The same strobe with DATA_DIR = 1 -> nothing stored.
- Fill 1024 words with enable = 1 and div = 16'hFFFF, then 5 more reads -> buf_afull = 1 from level 1008, overflow_cnt = 5, buf_level = 1024.
- In RUN, drop enable for 1 cycle -> IDLE, buf_level = 0, dac_data = 16'h8000, counters unchanged. Re-prime is required before strobes resume.
- Assert rst mid-RUN with the FIFO half full -> all outputs at reset values immediately (asynchronous). After release, the block behaves as after a fresh reset.
